// File: rtl/snn_step_controller.sv
// ---------------------------------------------------------------------------
// snn_step_controller
//
// Sequences one spiking-network inference run. It loads an image into the
// spike encoder, then issues TIME_STEPS time-step strobes. Each step waits
// for the downstream layer to acknowledge and for a minimum strobe spacing.
// A run ends in a one-cycle done pulse. It can also end early: a missing
// acknowledge sets a sticky timeout flag, and an abort returns the block to
// idle.
//
// Ports
//   clk              sole clock, rising edge
//   rst_n            synchronous active-low reset
//   start            request a run (only looked at in IDLE)
//   abort            drop the current run, back to IDLE next cycle
//   img_ready        pixel buffer holds a complete image (level)
//   layer_ack        network finished integrating the current step
//   pixel_valid      one-cycle load strobe to the encoder
//   time_step_pulse  one-cycle step-advance strobe to the encoder
//   step_idx         index of the current / most recent step
//   busy             high in every state except IDLE
//   done             one-cycle completion pulse
//   timeout_err      sticky: last run was ended by an acknowledge timeout
//   state_dbg        current FSM state encoding, for observation only
//
// Handshake semantics: start, img_ready and layer_ack are level inputs.
// They are sampled on the rising edge, and only in the states that consume
// them; in every other state they are ignored, with no buffering. A
// layer_ack seen in PULSE or WAIT_ACK is latched until the next PULSE.
// pixel_valid, time_step_pulse and done are single-cycle strobes with no
// back-pressure. All outputs are registered.
// ---------------------------------------------------------------------------
module snn_step_controller #(
  parameter int TIME_STEPS  = 100,
  parameter int STEP_CYCLES = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       img_ready,
  input  logic       layer_ack,
  output logic       pixel_valid,
  output logic       time_step_pulse,
  output logic [7:0] step_idx,
  output logic       busy,
  output logic       done,
  output logic       timeout_err,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_IMG = 3'd1,
    LOAD     = 3'd2,
    SETTLE   = 3'd3,
    PULSE    = 3'd4,
    WAIT_ACK = 3'd5,
    DONE     = 3'd6
  } state_t;

  localparam logic [7:0] LAST_STEP = 8'(TIME_STEPS - 1);
  localparam logic [8:0] STEP_LIM  = 9'(STEP_CYCLES);
  localparam logic [8:0] TO_LIM    = 9'(ACK_TIMEOUT);

  state_t     state, state_n;
  logic [7:0] gap_cnt;   // WAIT_ACK cycles since the last PULSE, minus one
  logic [7:0] tout_cnt;  // WAIT_ACK cycles spent without an acknowledge
  logic       ack_seen;

  logic       ack_now;
  logic       last_step;
  logic [8:0] elapsed;
  logic       gap_ok;
  logic       tout_hit;
  logic       timeout_fire;

  assign state_dbg = state;
  assign ack_now   = ack_seen | layer_ack;
  assign last_step = (step_idx == LAST_STEP);
  // Cycles between the PULSE cycle and the current WAIT_ACK cycle.
  assign elapsed   = {1'b0, gap_cnt} + 9'd1;
  // Leaving WAIT_ACK toward PULSE places the next strobe at elapsed+1, so the
  // spacing is met one cycle early. The final step instead stays in WAIT_ACK
  // for a full STEP_CYCLES after its strobe. This gives the network the
  // whole step window before done is raised.
  assign gap_ok    = last_step ? (elapsed >= STEP_LIM)
                               : ((elapsed + 9'd1) >= STEP_LIM);
  assign tout_hit  = !ack_now && (({1'b0, tout_cnt} + 9'd1) >= TO_LIM);

  always_comb begin
    state_n      = state;
    timeout_fire = 1'b0;
    case (state)
      IDLE:     if (start) state_n = img_ready ? LOAD : WAIT_IMG;
      WAIT_IMG: if (img_ready) state_n = LOAD;
      LOAD:     state_n = SETTLE;
      SETTLE:   state_n = PULSE;
      PULSE:    state_n = WAIT_ACK;
      WAIT_ACK: begin
        if (ack_now && gap_ok) begin
          state_n = last_step ? DONE : PULSE;
        end else if (tout_hit) begin
          state_n      = DONE;
          timeout_fire = 1'b1;
        end
      end
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    // Abort overrides every other transition, including a timeout.
    if (abort && state != IDLE) begin
      state_n      = IDLE;
      timeout_fire = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      gap_cnt         <= 8'd0;
      tout_cnt        <= 8'd0;
      ack_seen        <= 1'b0;
      pixel_valid     <= 1'b0;
      time_step_pulse <= 1'b0;
      step_idx        <= 8'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      state           <= state_n;
      // Strobes are registered from the next state, so they line up with
      // the cycle the FSM spends in LOAD / PULSE / DONE.
      pixel_valid     <= (state_n == LOAD);
      time_step_pulse <= (state_n == PULSE);
      busy            <= (state_n != IDLE);
      done            <= (state_n == DONE);

      if (state == IDLE && start) begin
        step_idx <= 8'd0;
      end else if (abort && state != IDLE) begin
        step_idx <= 8'd0;
      end else if (state == WAIT_ACK && state_n == PULSE) begin
        step_idx <= step_idx + 8'd1;
      end

      if (state == IDLE && start) begin
        timeout_err <= 1'b0;
      end else if (timeout_fire) begin
        timeout_err <= 1'b1;
      end

      if (state_n == PULSE) begin
        gap_cnt  <= 8'd0;
        tout_cnt <= 8'd0;
        ack_seen <= 1'b0;
      end else if (state_n == WAIT_ACK) begin
        ack_seen <= ack_now;
        if (state == WAIT_ACK) begin
          gap_cnt <= (gap_cnt == 8'hFF) ? gap_cnt : gap_cnt + 8'd1;
          if (!ack_seen) tout_cnt <= tout_cnt + 8'd1;
        end
      end else begin
        gap_cnt  <= 8'd0;
        tout_cnt <= 8'd0;
        ack_seen <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_snn_step_controller.sv
// ---------------------------------------------------------------------------
// tb_snn_step_controller
//
// Self-checking bench for snn_step_controller with TIME_STEPS=4,
// STEP_CYCLES=3 and ACK_TIMEOUT=10. Each run first chooses its
// acknowledge delays. A behavioural model then computes the cycle of every
// strobe and pushes those events onto exp_q. The model uses only the timing
// rules:
//   load at start+latency+1, first strobe two cycles later,
//   spacing max(STEP_CYCLES, delay+1, 2),
//   final done at max(STEP_CYCLES, delay)+1 after the last strobe,
//   timeout done at ACK_TIMEOUT+1 after the strobe.
// A monitor on the falling edge pops exp_q and compares it against
// whatever the DUT presents.
// ---------------------------------------------------------------------------
module tb_snn_step_controller;

  localparam int TS = 4;
  localparam int SC = 3;
  localparam int AT = 10;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0, abort = 1'b0, img_ready = 1'b0, layer_ack = 1'b0;
  logic       pixel_valid, time_step_pulse, busy, done, timeout_err;
  logic [7:0] step_idx;
  logic [2:0] state_dbg;

  snn_step_controller #(.TIME_STEPS(TS), .STEP_CYCLES(SC), .ACK_TIMEOUT(AT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .img_ready(img_ready), .layer_ack(layer_ack),
    .pixel_valid(pixel_valid), .time_step_pulse(time_step_pulse),
    .step_idx(step_idx), .busy(busy), .done(done),
    .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  // event word: {kind[1:0], busy, timeout_err, step[7:0], cycle[31:0]}
  // kind 1 = pixel_valid, 2 = time_step_pulse, 3 = done
  logic [43:0] exp_q[$];
  int total = 0;
  int bad = 0;
  bit chk_after_done = 1'b0;
  logic last_terr = 1'b0;

  function automatic logic [43:0] mk(input int kind, input logic b, input logic t,
                                     input int step, input int c);
    return {kind[1:0], b, t, step[7:0], c[31:0]};
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, want);
    end
  endtask

  task automatic take(input string name, input logic [43:0] got);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s unexpected at cycle %0d: got %0h, nothing expected", name, cyc, got);
    end else begin
      chk(name, {20'd0, got}, {20'd0, exp_q.pop_front()});
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (chk_after_done) begin
        chk_after_done = 1'b0;
        chk("busy_after_done", {63'd0, busy}, 64'd0);
        chk("terr_sticky", {63'd0, timeout_err}, {63'd0, last_terr});
      end
      chk("pv_tsp_exclusive", {63'd0, pixel_valid & time_step_pulse}, 64'd0);
      if (pixel_valid)
        take("pixel_valid", mk(1, busy, timeout_err, int'(step_idx), cyc));
      if (time_step_pulse)
        take("time_step_pulse", mk(2, busy, timeout_err, int'(step_idx), cyc));
      if (done) begin
        take("done", mk(3, busy, timeout_err, int'(step_idx), cyc));
        chk_after_done = 1'b1;
        last_terr = timeout_err;
      end
    end
  end

  // driver: one run
  // mode: 0 random delays with timeouts, 1 ack tied high, 2 delay 7,
  //       3 no ack (timeout on step 0), 4 random delays without timeouts
  // ctl:  0 none, 1 abort in the cycle after strobe ctl_step,
  //       2 reset in the cycle after strobe ctl_step
  task automatic run(input int img_lat, input int mode, input int ctl,
                     input int ctl_step, input bit chain);
    int s, pv, done_c, end_c, hold;
    int p[TS];
    int d[TS];
    bit ack_at[int];
    bit ctl_hit;
    s = cyc;
    pv = s + img_lat + 1;
    p[0] = pv + 2;
    done_c = -1;
    end_c = -1;
    ctl_hit = 1'b0;
    for (int k = 0; k < TS; k++) begin
      case (mode)
        0: d[k] = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 10));
        1: d[k] = 0;
        2: d[k] = 7;
        3: d[k] = -1;
        default: d[k] = int'($urandom_range(0, 10));
      endcase
    end
    exp_q.push_back(mk(1, 1'b1, 1'b0, 0, pv));
    for (int k = 0; k < TS; k++) begin
      exp_q.push_back(mk(2, 1'b1, 1'b0, k, p[k]));
      if (d[k] >= 0 && mode != 1) ack_at[p[k] + d[k]] = 1'b1;
      if (ctl != 0 && k == ctl_step) begin
        end_c = p[k] + 1;
        ctl_hit = 1'b1;
        break;
      end
      if (d[k] < 0) begin
        done_c = p[k] + AT + 1;
        exp_q.push_back(mk(3, 1'b1, 1'b1, k, done_c));
        break;
      end
      if (k == TS - 1) begin
        done_c = p[k] + max2(SC, d[k]) + 1;
        exp_q.push_back(mk(3, 1'b1, 1'b0, k, done_c));
      end else begin
        p[k + 1] = p[k] + max2(max2(SC, d[k] + 1), 2);
      end
    end
    if (done_c >= 0) end_c = done_c;
    hold = int'($urandom_range(1, 3));
    while (cyc <= end_c) begin
      start = ((cyc - s) < hold) || (chain && cyc == done_c);
      img_ready = (cyc >= s + img_lat);
      abort = (ctl == 1 && ctl_hit && cyc == end_c);
      rst_n = !(ctl == 2 && ctl_hit && cyc == end_c);
      if (mode == 1) layer_ack = 1'b1;
      else if (cyc < p[0]) layer_ack = 1'($urandom_range(0, 1));
      else layer_ack = ack_at.exists(cyc) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
    end
    abort = 1'b0;
    rst_n = 1'b1;
    layer_ack = 1'b0;
    if (!(chain && done_c >= 0)) start = 1'b0;
    if (ctl_hit) begin
      @(negedge clk);
      chk("idle_busy", {63'd0, busy}, 64'd0);
      chk("idle_step_idx", {56'd0, step_idx}, 64'd0);
      chk("idle_strobes", {61'd0, done, pixel_valid, time_step_pulse}, 64'd0);
      if (ctl == 2) chk("reset_terr", {63'd0, timeout_err}, 64'd0);
      @(posedge clk);
      #1;
    end
    if (!(chain && done_c >= 0)) begin
      repeat ($urandom_range(0, 3)) begin
        layer_ack = 1'($urandom_range(0, 1));
        img_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
      layer_ack = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_outputs",
        {50'd0, pixel_valid, time_step_pulse, busy, done, timeout_err, step_idx, 1'b0},
        64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(0, 1, 0, 0, 1'b0);   // normal run, ack tied high
    run(0, 2, 0, 0, 1'b0);   // slow ack, 8-cycle spacing
    run(0, 3, 0, 0, 1'b0);   // timeout on the first step
    run(0, 1, 0, 0, 1'b0);   // start clears timeout_err
    run(0, 4, 1, 2, 1'b0);   // abort after the step-2 strobe
    run(0, 1, 0, 0, 1'b0);   // normal run after abort
    run(5, 4, 0, 0, 1'b1);   // late image, start held through done
    run(0, 4, 0, 0, 1'b0);   // retriggered run from the held start
    run(0, 4, 2, 1, 1'b0);   // reset during WAIT_ACK of step 1
    run(0, 1, 0, 0, 1'b0);

    repeat (25) begin
      int lat, ctl;
      lat = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 6));
      ctl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      run(lat, 0, ctl, int'($urandom_range(0, TS - 1)), 1'($urandom_range(0, 1)));
    end
    start = 1'b0;

    repeat (6) @(posedge clk);
    #1;
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
